// File: rtl/crc32_stream_pkg.sv
// Shared constants, state encoding and helpers for the streaming CRC-32 engine.
package crc32_stream_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    localparam int unsigned MODE_GEN   = 0;
    localparam int unsigned MODE_CHECK = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_APPEND = 2'd2
    } state_e;

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

endpackage

// File: rtl/crc32_stream_if.sv
// Input and output stream handshake bundle around the CRC engine.
interface crc32_stream_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    // slave: the engine; master: upstream source plus downstream sink
    modport slave  (input  s_data, s_valid, s_last, m_ready,
                    output s_ready, m_data, m_valid, m_last);
    modport master (output s_data, s_valid, s_last, m_ready,
                    input  s_ready, m_data, m_valid, m_last);
endinterface

// File: rtl/crc32_next.sv
// Combinational CRC-32 advance by DATA_W bits, byte 0 = data[7:0] processed first.
module crc32_next
    import crc32_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter bit          REFLECT = 1'b1
) (
    input  logic [31:0]       crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc_out
);

    localparam logic [31:0] POLY_R = bitrev32(POLY);

    always_comb begin
        logic [31:0] c;
        logic        fb;
        c  = crc_in;
        fb = 1'b0;
        for (int b = 0; b < int'(DATA_W / 8); b++) begin
            for (int k = 0; k < 8; k++) begin
                // reflected: LSB of each byte first; normal: MSB first
                if (REFLECT) begin
                    fb = c[0] ^ data[8*b + k];
                    c  = {1'b0, c[31:1]} ^ (fb ? POLY_R : 32'h0);
                end else begin
                    fb = c[31] ^ data[8*b + 7 - k];
                    c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
                end
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32: pass-through with appended CRC (GEN) or residue check (CHECK).
module crc32_stream
    import crc32_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MODE    = MODE_GEN,
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] XOROUT  = CRC32_XOROUT,
    parameter bit          REFLECT = 1'b1,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
    input  logic           clk,
    input  logic           rst,
    crc32_stream_if.slave  bus,
    output logic [31:0]    crc_value,
    output logic           crc_done,
    output logic           crc_ok
);

    localparam int unsigned N_SLICE = 32 / DATA_W;
    localparam int unsigned CNT_W   = 3;

    state_e              state_q, state_d;
    logic [31:0]         crc_q, crc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                run_q;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [31:0]         crc_value_q, crc_value_d;
    logic                crc_done_q, crc_done_d;
    logic                crc_ok_q, crc_ok_d;

    logic [31:0]         crc_upd, crc_cmp;
    logic [CNT_W-1:0]    slice_idx;
    logic                out_free, s_ready_c, s_fire, m_fire;

    crc32_next #(.DATA_W(DATA_W), .POLY(POLY), .REFLECT(REFLECT)) u_next (
        .crc_in  (crc_q),
        .data    (bus.s_data),
        .crc_out (crc_upd)
    );

    assign out_free  = !m_valid_q || bus.m_ready;
    assign s_ready_c = run_q && (state_q != ST_APPEND) && out_free;
    assign s_fire    = bus.s_valid && s_ready_c;
    assign m_fire    = m_valid_q && bus.m_ready;
    // residue is expressed in normal bit order, the register is held reflected
    assign crc_cmp   = REFLECT ? bitrev32(crc_upd) : crc_upd;
    assign slice_idx = REFLECT ? cnt_q : CNT_W'(N_SLICE - 1) - cnt_q;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        crc_value_d = crc_value_q;
        crc_done_d  = 1'b0;
        crc_ok_d    = crc_ok_q;
        if (m_fire) m_valid_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (s_fire) begin
                    m_data_d  = bus.s_data;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    crc_d     = crc_upd;
                    state_d   = ST_DATA;
                    if (bus.s_last) begin
                        if (MODE == MODE_CHECK) begin
                            m_last_d    = 1'b1;
                            crc_done_d  = 1'b1;
                            crc_ok_d    = (crc_cmp == RESIDUE);
                            crc_value_d = crc_upd ^ XOROUT;
                            crc_d       = INIT;
                            state_d     = ST_IDLE;
                        end else begin
                            // crc_q carries the final post-XOROUT value while appending
                            crc_d   = crc_upd ^ XOROUT;
                            cnt_d   = '0;
                            state_d = ST_APPEND;
                        end
                    end
                end
            end
            ST_APPEND: begin
                if (m_fire && m_last_q) begin
                    crc_done_d  = 1'b1;
                    crc_ok_d    = 1'b1;
                    crc_value_d = crc_q;
                    crc_d       = INIT;
                    state_d     = ST_IDLE;
                end else if (out_free && (cnt_q < CNT_W'(N_SLICE))) begin
                    m_data_d  = DATA_W'(crc_q >> (DATA_W * 32'(slice_idx)));
                    m_valid_d = 1'b1;
                    m_last_d  = (cnt_q == CNT_W'(N_SLICE - 1));
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            crc_value_q <= '0;
            crc_done_q  <= 1'b0;
            crc_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            run_q       <= 1'b1;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            crc_value_q <= crc_value_d;
            crc_done_q  <= crc_done_d;
            crc_ok_q    <= crc_ok_d;
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign crc_value   = crc_value_q;
    assign crc_done    = crc_done_q;
    assign crc_ok      = crc_ok_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream: GEN at 8/16/32 bits, CHECK at 8 bits, reset abort.
module tb_crc32_stream;
    import crc32_stream_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;
    int last_acc = 0;

    crc32_stream_if #(.DATA_W(8))  if_g8  ();
    crc32_stream_if #(.DATA_W(32)) if_g32 ();
    crc32_stream_if #(.DATA_W(8))  if_c8  ();
    crc32_stream_if #(.DATA_W(16)) if_g16 ();

    logic [31:0] v_g8, v_g32, v_c8, v_g16;
    logic        d_g8, d_g32, d_c8, d_g16;
    logic        k_g8, k_g32, k_c8, k_g16;

    crc32_stream #(.DATA_W(8),  .MODE(MODE_GEN))   u_g8  (.clk(clk), .rst(rst), .bus(if_g8),
        .crc_value(v_g8),  .crc_done(d_g8),  .crc_ok(k_g8));
    crc32_stream #(.DATA_W(32), .MODE(MODE_GEN))   u_g32 (.clk(clk), .rst(rst), .bus(if_g32),
        .crc_value(v_g32), .crc_done(d_g32), .crc_ok(k_g32));
    crc32_stream #(.DATA_W(8),  .MODE(MODE_CHECK)) u_c8  (.clk(clk), .rst(rst), .bus(if_c8),
        .crc_value(v_c8),  .crc_done(d_c8),  .crc_ok(k_c8));
    crc32_stream #(.DATA_W(16), .MODE(MODE_GEN))   u_g16 (.clk(clk), .rst(rst), .bus(if_g16),
        .crc_value(v_g16), .crc_done(d_g16), .crc_ok(k_g16));

    // output and completion monitors, sampled mid-cycle
    logic [32:0] rx_g8[$], rx_g32[$], rx_c8[$], rx_g16[$];
    logic [31:0] val_g8[$], val_c8[$];
    logic        ok_c8[$];
    int          n_done[4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (if_g8.m_valid  && if_g8.m_ready)  rx_g8.push_back({if_g8.m_last,  32'(if_g8.m_data)});
        if (if_g32.m_valid && if_g32.m_ready) rx_g32.push_back({if_g32.m_last, if_g32.m_data});
        if (if_c8.m_valid  && if_c8.m_ready)  rx_c8.push_back({if_c8.m_last,  32'(if_c8.m_data)});
        if (if_g16.m_valid && if_g16.m_ready) rx_g16.push_back({if_g16.m_last, 32'(if_g16.m_data)});
        if (d_g8)  begin n_done[0] <= n_done[0] + 1; val_g8.push_back(v_g8); end
        if (d_g32) n_done[1] <= n_done[1] + 1;
        if (d_c8)  begin n_done[2] <= n_done[2] + 1; val_c8.push_back(v_c8); ok_c8.push_back(k_c8); end
        if (d_g16) n_done[3] <= n_done[3] + 1;
    end

    logic        stall_prev = 1'b0;
    logic [32:0] stall_beat = '0;
    int          stall_err  = 0;
    always @(negedge clk) begin
        if (stall_prev && (!if_g16.m_valid || {if_g16.m_last, 32'(if_g16.m_data)} != stall_beat))
            stall_err <= stall_err + 1;
        stall_prev <= if_g16.m_valid && !if_g16.m_ready;
        stall_beat <= {if_g16.m_last, 32'(if_g16.m_data)};
    end

    task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sw_crc(input byte_q_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c ^= {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byte_q_t str2q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic put(input int sel, input logic v, input logic [31:0] d, input logic l);
        case (sel)
            0: begin if_g8.s_valid  = v; if_g8.s_data  = d[7:0];  if_g8.s_last  = l; end
            1: begin if_g32.s_valid = v; if_g32.s_data = d;       if_g32.s_last = l; end
            2: begin if_c8.s_valid  = v; if_c8.s_data  = d[7:0];  if_c8.s_last  = l; end
            default: begin if_g16.s_valid = v; if_g16.s_data = d[15:0]; if_g16.s_last = l; end
        endcase
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0: return if_g8.s_ready;
            1: return if_g32.s_ready;
            2: return if_c8.s_ready;
            default: return if_g16.s_ready;
        endcase
    endfunction

    task automatic send(input int sel, input logic [31:0] d, input logic l);
        int   g   = 0;
        logic acc = 1'b0;
        put(sel, 1'b1, d, l);
        while (!acc && g < 200) begin
            @(negedge clk);
            acc = rdy(sel);
            if (acc) last_acc = cyc;
            @(posedge clk); #2;
            g++;
        end
        check_val("beat_accept", 33'(acc), 33'd1);
        put(sel, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic send_frame(input int sel, input int bpb, input byte_q_t b,
                              output int c_first, output int c_last);
        int nb = b.size() / bpb;
        logic [31:0] d;
        c_first = 0;
        for (int i = 0; i < nb; i++) begin
            d = '0;
            for (int k = 0; k < bpb; k++) d[8*k +: 8] = b[i*bpb + k];
            send(sel, d, i == nb - 1);
            if (i == 0) c_first = last_acc;
        end
        c_last = last_acc;
    endtask

    task automatic wait_done(input int sel, input int target);
        int g = 0;
        while (n_done[sel] < target && g < 400) begin
            @(negedge clk);
            g++;
        end
        check_val("done_count", 33'(n_done[sel]), 33'(target));
        @(posedge clk); #2;
    endtask

    bit stop16 = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t msg, zero1, zero4, good, bad, m16;
        logic [32:0] exp_q[$];
        logic [31:0] e16;
        int f1, l1, f2, l2, nd;

        msg   = str2q("123456789");
        m16   = str2q("1234567890");
        zero1 = {}; zero1.push_back(8'h00);
        zero4 = {}; for (int i = 0; i < 4; i++) zero4.push_back(8'h00);
        good  = msg;
        good.push_back(8'h26); good.push_back(8'h39); good.push_back(8'hF4); good.push_back(8'hCB);
        bad   = good;
        bad[3] = 8'h35;

        rst = 1'b0;
        for (int s = 0; s < 4; s++) put(s, 1'b0, 32'h0, 1'b0);
        if_g8.m_ready = 1'b1; if_g32.m_ready = 1'b1; if_c8.m_ready = 1'b1; if_g16.m_ready = 1'b1;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_s_ready",  33'(if_g8.s_ready), 33'd0);
        check_val("rst_m_valid",  33'(if_g8.m_valid), 33'd0);
        check_val("rst_m_last",   33'(if_g8.m_last),  33'd0);
        check_val("rst_m_data",   33'(if_g8.m_data),  33'd0);
        check_val("rst_crc_value", 33'(v_g8), 33'd0);
        check_val("rst_crc_done", 33'(d_g8), 33'd0);
        check_val("rst_crc_ok",   33'(k_c8), 33'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_val("s_ready_at_release", 33'(if_g8.s_ready), 33'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("s_ready_after_release", 33'(if_g8.s_ready), 33'd1);
        @(posedge clk); #2;

        // GEN 8-bit, "123456789"
        rx_g8.delete();
        send_frame(0, 1, msg, f1, l1);
        check_val("g8_rate", 33'(l1 - f1), 33'd8);
        wait_done(0, 1);
        exp_q.delete();
        foreach (msg[i]) exp_q.push_back({1'b0, 24'h0, msg[i]});
        exp_q.push_back(33'h0_0000_0026); exp_q.push_back(33'h0_0000_0039);
        exp_q.push_back(33'h0_0000_00F4); exp_q.push_back(33'h1_0000_00CB);
        check_val("g8_rx_count", 33'(rx_g8.size()), 33'd13);
        foreach (exp_q[i]) if (i < rx_g8.size()) check_val("g8_beat", rx_g8[i], exp_q[i]);
        check_val("g8_crc_value", 33'(v_g8), 33'h0CBF43926);
        check_val("g8_crc_ok", 33'(k_g8), 33'd1);

        // GEN 8-bit back-to-back frames
        rx_g8.delete();
        send_frame(0, 1, msg, f1, l1);
        send_frame(0, 1, zero1, f2, l2);
        check_val("g8_b2b_gap", 33'(f2 - l1), 33'd6);
        wait_done(0, 3);
        check_val("g8_b2b_val1", 33'(val_g8[1]), 33'h0CBF43926);
        check_val("g8_b2b_val2", 33'(val_g8[2]), 33'h0D202EF8D);
        check_val("g8_b2b_rx_count", 33'(rx_g8.size()), 33'd18);
        if (rx_g8.size() == 18) begin
            check_val("g8_b2b_f2_data", rx_g8[13], 33'h0_0000_0000);
            check_val("g8_b2b_f2_crc0", rx_g8[14], 33'h0_0000_008D);
            check_val("g8_b2b_f2_crc3", rx_g8[17], 33'h1_0000_00D2);
        end

        // GEN 32-bit, single zero beat
        rx_g32.delete();
        send_frame(1, 4, zero4, f1, l1);
        wait_done(1, 1);
        check_val("g32_rx_count", 33'(rx_g32.size()), 33'd2);
        if (rx_g32.size() == 2) begin
            check_val("g32_beat0", rx_g32[0], 33'h0_0000_0000);
            check_val("g32_beat1", rx_g32[1], 33'h1_2144DF1C);
        end
        check_val("g32_crc_value", 33'(v_g32), 33'h02144DF1C);

        // CHECK 8-bit: good frame then corrupted frame, back to back
        rx_c8.delete();
        send_frame(2, 1, good, f1, l1);
        send_frame(2, 1, bad, f2, l2);
        check_val("c8_b2b_gap", 33'(f2 - l1), 33'd1);
        wait_done(2, 2);
        check_val("c8_ok_good", 33'(ok_c8[0]), 33'd1);
        check_val("c8_value_good", 33'(val_c8[0]), 33'h02144DF1C);
        check_val("c8_ok_bad", 33'(ok_c8[1]), 33'd0);
        check_val("c8_rx_count", 33'(rx_c8.size()), 33'd26);
        if (rx_c8.size() == 26) begin
            check_val("c8_beat11", rx_c8[11], 33'h0_0000_00F4);
            check_val("c8_beat12_last", rx_c8[12], 33'h1_0000_00CB);
        end

        // GEN 16-bit with random downstream stalls
        rx_g16.delete();
        fork
            begin
                while (!stop16) begin
                    @(posedge clk); #2;
                    if_g16.m_ready = 1'($urandom_range(0, 1));
                end
                if_g16.m_ready = 1'b1;
            end
        join_none
        send_frame(3, 2, m16, f1, l1);
        wait_done(3, 1);
        stop16 = 1'b1;
        repeat (3) @(posedge clk); #2;
        e16 = sw_crc(m16);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 16'h0, m16[2*i+1], m16[2*i]});
        exp_q.push_back({1'b0, 16'h0, e16[15:0]});
        exp_q.push_back({1'b1, 16'h0, e16[31:16]});
        check_val("g16_rx_count", 33'(rx_g16.size()), 33'd7);
        foreach (exp_q[i]) if (i < rx_g16.size()) check_val("g16_beat", rx_g16[i], exp_q[i]);
        check_val("g16_crc_value", 33'(v_g16), 33'(e16));
        check_val("g16_stall_stable", 33'(stall_err), 33'd0);

        // reset mid-frame, then a clean frame
        nd = n_done[0];
        for (int i = 0; i < 4; i++) send(0, 32'(msg[i]), 1'b0);
        rst = 1'b0;
        #1;
        check_val("abort_m_valid",   33'(if_g8.m_valid), 33'd0);
        check_val("abort_m_data",    33'(if_g8.m_data),  33'd0);
        check_val("abort_s_ready",   33'(if_g8.s_ready), 33'd0);
        check_val("abort_crc_value", 33'(v_g8), 33'd0);
        check_val("abort_crc_ok",    33'(k_g8), 33'd0);
        repeat (2) @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk); #2;
        check_val("abort_no_done", 33'(n_done[0]), 33'(nd));
        rx_g8.delete();
        send_frame(0, 1, msg, f1, l1);
        wait_done(0, nd + 1);
        check_val("abort_crc_value_after", 33'(v_g8), 33'h0CBF43926);
        check_val("abort_rx_count", 33'(rx_g8.size()), 33'd13);
        if (rx_g8.size() == 13) check_val("abort_last_beat", rx_g8[12], 33'h1_0000_00CB);

        // no stray completions afterwards
        repeat (10) @(posedge clk);
        check_val("final_done_g8",  33'(n_done[0]), 33'(nd + 1));
        check_val("final_done_g32", 33'(n_done[1]), 33'd1);
        check_val("final_done_c8",  33'(n_done[2]), 33'd2);
        check_val("final_done_g16", 33'(n_done[3]), 33'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
